funct_generator_fifo_reader: RTL
================================

Name: funct_generator_fifo_reader

Overview:
- Drain side of the generator sample FIFO: pops signed waveform samples at a programmable sample rate and presents them to the output stage (DAC interface) with a valid/ready handshake.
- Sits between the sample FIFO read port and the DAC driver.
- Samples use the generator's signed fixed-point format, Q4.(DATA_WIDTH-4), bit range [3:4-DATA_WIDTH].

Parameters:
DATA_WIDTH, 32, sample width in bits; the signed range is [3:4-DATA_WIDTH].
DIV_WIDTH, 16, width of the sample-period divider.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset, asynchronous, active-low
en_i  input  1  sample-rate tick enable
div_i  input  DIV_WIDTH  sample period minus 1, in clk_i cycles
fifo_empty_i  input  1  FIFO empty flag
fifo_rd_o  output  1  FIFO pop request; one-cycle pulse
fifo_data_i  input  signed [3:4-DATA_WIDTH]  FIFO read data, valid 1 cycle after fifo_rd_o
data_o  output  signed [3:4-DATA_WIDTH]  presented sample; held between updates
valid_o  output  1  data_o holds a new sample
ready_i  input  1  downstream accepts the sample
underflow_o  output  1  one-cycle pulse: a tick found the FIFO empty
stall_o  output  1  one-cycle pulse: a tick was dropped because the FSM was busy

Behaviour:
- Clock and reset: single clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: data_o=0, valid_o=0, fifo_rd_o=0, underflow_o=0, stall_o=0, divider count=0, state=IDLE.
- Reset mid-operation forces reset values immediately; an in-flight pop is discarded.
- Divider:
  - en_i=1: count runs 0..div_i; tick when count==div_i, and count reloads to 0 on the same edge.
  - en_i=0: count held at 0, no ticks.
  - div_i=0: tick every cycle.
  - div_i changes take effect at the next compare.
- FSM states: IDLE, READ, CAPTURE, PRESENT.
  - IDLE, tick, !fifo_empty_i: -> READ.
  - IDLE, tick, fifo_empty_i: underflow_o=1 next cycle; stay IDLE; data_o unchanged (hold last sample).
  - READ: fifo_rd_o=1 for exactly this cycle; -> CAPTURE.
  - CAPTURE: data_o <= fifo_data_i; valid_o <= 1; -> PRESENT.
  - PRESENT: hold data_o and valid_o until ready_i=1. The cycle with valid_o&&ready_i is the transfer; next edge: valid_o=0, -> IDLE.
  - A tick while not in IDLE is dropped; stall_o=1 next cycle. Ticks are never queued.
- Latency and throughput:
  - Tick to fifo_rd_o: 1 cycle.
  - Tick to valid_o: 3 cycles.
  - Minimum sample period is 4 cycles with ready_i tied high (div_i>=3 gives no stalls).
- fifo_rd_o is never asserted when fifo_empty_i was high on the deciding tick. This block is the FIFO's sole reader.
- en_i falling mid-transaction: the current READ/CAPTURE/PRESENT sequence completes normally; no new ticks are generated.
- Simultaneous events:
  - Tick in the same cycle as the PRESENT transfer counts as busy: stall_o pulses, and the next sample waits for the next tick.
  - Underflow and stall never pulse in the same cycle.
- data_o passes through unmodified: no sign extension, rounding or saturation.

Optional Feature:
Macro FGEN_RD_UNDERFLOW_CNT_EN.
- Defined:
  - Adds output underflow_cnt_o [15:0], a saturating count of underflow_o pulses.
  - Reset value 0; cleared only by reset; sticks at 16'hFFFF.
  - Increments in the same cycle underflow_o is high.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Basic pop
   - Stimulus: reset, FIFO holds 32'sh1000_0000, div_i=9, en_i=1, ready_i=1.
   - Response: fifo_rd_o pulses 1 cycle after the tick; valid_o high 3 cycles after the tick with data_o=32'sh1000_0000; valid_o low the following cycle.
2. Underflow
   - Stimulus: FIFO empty, div_i=4, en_i=1, for 20 cycles.
   - Response: underflow_o pulses 4 times (every 5 cycles); fifo_rd_o never high; data_o holds its previous value. With FGEN_RD_UNDERFLOW_CNT_EN, underflow_cnt_o=4.
3. Backpressure
   - Stimulus: sample 32'shF000_0001 captured, ready_i=0 for 12 cycles, div_i=3.
   - Response: valid_o and data_o stable for all 12 cycles; stall_o pulses on each tick during the hold; exactly one pop per transfer.
4. Max rate
   - Stimulus: div_i=0, ready_i=1, FIFO holds 8 samples.
   - Response: one transfer every 4 cycles; stall_o pulses on 3 of every 4 cycles; samples leave in FIFO order.
5. Async reset mid-operation
   - Stimulus: assert rst_n_i=0 between edges while in CAPTURE.
   - Response: valid_o, fifo_rd_o and data_o go to 0 immediately, without waiting for a clock edge; after release, no sample appears until the next tick.
6. Enable drop
   - Stimulus: en_i falls in the cycle after fifo_rd_o.
   - Response: the sample still completes its valid/ready transfer; no further ticks, pops or underflows while en_i=0.

Source files
------------

// File: rtl/funct_generator_fifo_reader.sv
// Drain side of the generator sample FIFO: pops samples at a programmable rate and presents them with valid/ready.
// Optional macro FGEN_RD_UNDERFLOW_CNT_EN adds a saturating underflow counter output (underflow_cnt_o).
module funct_generator_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic                          fifo_empty_i,
    output logic                          fifo_rd_o,
    input  logic signed [3:4-DATA_WIDTH]  fifo_data_i,
    output logic signed [3:4-DATA_WIDTH]  data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          underflow_o,
`ifdef FGEN_RD_UNDERFLOW_CNT_EN
    output logic [15:0]                   underflow_cnt_o,
`endif
    output logic                          stall_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        PRESENT
    } state_t;

    state_t                         state_q, state_d;
    logic [DIV_WIDTH-1:0]           count_q, count_d;
    logic signed [3:4-DATA_WIDTH]   data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           rd_q, rd_d;
    logic                           underflow_q, underflow_d;
    logic                           stall_q, stall_d;
    logic                           tick;

    always_comb begin
        tick    = en_i && (count_q == div_i);
        // Count reloads on the tick edge and is pinned at zero while disabled.
        count_d = (en_i && !tick) ? count_q + DIV_WIDTH'(1) : '0;
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        rd_d        = 1'b0;
        underflow_d = 1'b0;
        stall_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (fifo_empty_i) begin
                        underflow_d = 1'b1;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = fifo_data_i;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ticks outside IDLE are dropped, never queued.
        if (tick && (state_q != IDLE)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            rd_q        <= 1'b0;
            underflow_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            underflow_q <= underflow_d;
            stall_q     <= stall_d;
        end
    end

`ifdef FGEN_RD_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (underflow_d && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt_o = ucnt_q;
`endif

    assign fifo_rd_o   = rd_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign underflow_o = underflow_q;
    assign stall_o     = stall_q;

endmodule
